maindec_seq: RTL and testbench
==============================

Name: maindec_seq

Overview:
Registered, parametrised successor to the combinational main decoder. It decodes the RV32I opcode into the existing control word and registers it into the ID/EX boundary with one cycle of latency. It also expands the custom memcopy opcode (7'b1000011) into a burst of L word-copy micro-ops, with L taken from the instruction. A busy output back-pressures fetch/decode while a burst is in progress.

Parameters:
CNT_W, 5, width of the memcopy length field; max burst is 2^CNT_W-1 words
MEMCPY_OP, 7'b1000011, opcode treated as memcopy

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  decode-stage instruction valid
op  in  7  instruction opcode
len  in  CNT_W  memcopy word count L (instruction field); ignored for other opcodes
stall_in  in  1  hazard-unit stall; freezes the block
flush_in  in  1  branch/jump flush; kills output and aborts a burst
ALUSrc, ALUOp[2], RegWrite, Branch, immSrc[3], memwrite1, memwrite2, wdsel[2], jump, resultsrc[2], jumpsel  out  -  registered control word, same meanings as the existing decoder
valid_out  out  1  control word is valid this cycle
uop_idx  out  CNT_W  word offset of the current memcopy micro-op (0 for non-memcopy)
uop_last  out  1  final micro-op of an instruction (1 for every non-memcopy valid op)
busy  out  1  burst in progress; upstream must hold and not present new instructions
illegal  out  1  unknown opcode (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): every output is 0, FSM is IDLE, remaining count is 0. A reset mid-burst abandons the burst immediately.
- Control word field order: ALUSrc,ALUOp,RegWrite,Branch,immSrc,memwrite1,memwrite2,wdsel,jump,resultsrc,jumpsel. No x values; all don't-cares are 0.
  - R 0110011: 0_10_1_0_000_0_0_00_0_00_0
  - I-ALU 0010011: 1_10_1_0_000_0_0_00_0_00_0
  - Branch 1100011: 0_01_0_1_001_0_0_00_0_00_0
  - Load 0000011: 1_00_1_0_000_0_0_01_0_01_0
  - Store 0100011: 1_00_0_0_010_1_0_00_0_00_0
  - JAL 1101111: 0_00_1_0_011_0_0_00_1_10_0
  - JALR 1100111: 0_00_1_0_000_0_0_00_1_10_1
  - LUI 0110111: 0_00_1_0_100_0_0_10_0_00_0
  - AUIPC 0010111: 0_00_1_0_100_0_0_11_0_00_0
  - MEMCPY: 1_00_0_0_010_0_1_00_0_00_0
- Priority on each rising edge: reset > flush_in > stall_in > normal operation.
- flush_in=1: all outputs go to 0 next cycle, FSM goes to IDLE, any remaining burst is discarded. Flush wins over a simultaneous stall.
- stall_in=1 (no flush): all registers hold, including FSM state, uop_idx and the remaining count.
- IDLE, valid_in=1:
  - Non-memcopy op: the control word appears next cycle with valid_out=1, uop_idx=0, uop_last=1.
  - MEMCPY with L=0: treated as a NOP. Next cycle valid_out=0 and the control word is all 0.
  - MEMCPY with L=1: one micro-op, uop_idx=0, uop_last=1, FSM stays IDLE.
  - MEMCPY with L>1: first micro-op is output next cycle (uop_idx=0, uop_last=0). The control word and a remaining count of L-1 are latched, and the FSM moves to COPY.
- IDLE, valid_in=0: valid_out=0 and the control word is 0 next cycle.
- COPY: busy=1 combinationally (busy = state==COPY). valid_in, op and len are ignored.
  - Each unstalled edge: uop_idx+1, remaining-1, control word re-issued with valid_out=1.
  - When remaining reaches 0 on an edge, that micro-op has uop_last=1 and the FSM returns to IDLE. busy is therefore 0 in the cycle the last micro-op is visible, and a new instruction is accepted that same cycle.
- Burst timing for L accepted at cycle T: micro-ops are visible at T+1..T+L, busy=1 at T+1..T+L-1.
- uop_idx never wraps, because L is at most 2^CNT_W-1.

Optional Feature:
- MAINDEC_ILLEGAL_EN defined: an unknown opcode with valid_in produces valid_out=1, illegal=1 and an all-0 control word next cycle. illegal is cleared by any other accepted input, by flush and by reset.
- Undefined: illegal is tied to 0, and an unknown opcode behaves as a NOP (valid_out=0).

Test Plan:
- Reset then R-type 0110011, valid_in=1 -> next cycle: valid_out=1, control word 0_10_1_0_000_0_0_00_0_00_0, uop_last=1, busy=0.
- MEMCPY with len=3 at cycle T -> uop_idx 0,1,2 at T+1..T+3; uop_last only at T+3; busy=1 at T+1,T+2; memwrite2=1 throughout.
- MEMCPY len=4 with stall_in=1 for 2 cycles after the first micro-op -> uop_idx holds at 0 for the stalled cycles, then 1,2,3; total busy cycles = 3+2.
- MEMCPY len=5 with flush_in at the 2nd micro-op -> next cycle valid_out=0, busy=0, FSM IDLE; a following JAL decodes as 0_00_1_0_011_0_0_00_1_10_0.
- MEMCPY len=0, then len=1 -> first gives valid_out=0; second gives a single micro-op with uop_last=1 and busy never asserted.
- Opcode 1111111 valid -> with MAINDEC_ILLEGAL_EN: illegal=1, valid_out=1; without: valid_out=0, illegal=0. reset_n pulled low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/maindec_seq.sv
// Registered RV32I main decoder with memcopy burst expansion into word-copy micro-ops.
// Optional illegal-opcode reporting is enabled by defining MAINDEC_ILLEGAL_EN.
module maindec_seq #(
    parameter int unsigned CNT_W     = 5,
    parameter logic [6:0]  MEMCPY_OP = 7'b1000011
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [6:0]       op,
    input  logic [CNT_W-1:0] len,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             Branch,
    output logic [2:0]       immSrc,
    output logic             memwrite1,
    output logic             memwrite2,
    output logic [1:0]       wdsel,
    output logic             jump,
    output logic [1:0]       resultsrc,
    output logic             jumpsel,
    output logic             valid_out,
    output logic [CNT_W-1:0] uop_idx,
    output logic             uop_last,
    output logic             busy,
    output logic             illegal
);

    localparam int unsigned CW_W = 16;

    // Field order: ALUSrc,ALUOp,RegWrite,Branch,immSrc,memwrite1,memwrite2,wdsel,jump,resultsrc,jumpsel
    localparam logic [CW_W-1:0] CW_R      = 16'b0_10_1_0_000_0_0_00_0_00_0;
    localparam logic [CW_W-1:0] CW_I      = 16'b1_10_1_0_000_0_0_00_0_00_0;
    localparam logic [CW_W-1:0] CW_BR     = 16'b0_01_0_1_001_0_0_00_0_00_0;
    localparam logic [CW_W-1:0] CW_LD     = 16'b1_00_1_0_000_0_0_01_0_01_0;
    localparam logic [CW_W-1:0] CW_ST     = 16'b1_00_0_0_010_1_0_00_0_00_0;
    localparam logic [CW_W-1:0] CW_JAL    = 16'b0_00_1_0_011_0_0_00_1_10_0;
    localparam logic [CW_W-1:0] CW_JALR   = 16'b0_00_1_0_000_0_0_00_1_10_1;
    localparam logic [CW_W-1:0] CW_LUI    = 16'b0_00_1_0_100_0_0_10_0_00_0;
    localparam logic [CW_W-1:0] CW_AUIPC  = 16'b0_00_1_0_100_0_0_11_0_00_0;
    localparam logic [CW_W-1:0] CW_MEMCPY = 16'b1_00_0_0_010_0_1_00_0_00_0;

    typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              illegal_q, illegal_d;

    logic [CW_W-1:0]   dec_cw;
    logic              dec_known;
    logic              is_memcpy;

    // Plain opcode decode; memcopy is recognised separately and takes priority.
    always_comb begin
        dec_cw    = '0;
        dec_known = 1'b1;
        is_memcpy = (op == MEMCPY_OP);
        case (op)
            7'b0110011: dec_cw = CW_R;
            7'b0010011: dec_cw = CW_I;
            7'b1100011: dec_cw = CW_BR;
            7'b0000011: dec_cw = CW_LD;
            7'b0100011: dec_cw = CW_ST;
            7'b1101111: dec_cw = CW_JAL;
            7'b1100111: dec_cw = CW_JALR;
            7'b0110111: dec_cw = CW_LUI;
            7'b0010111: dec_cw = CW_AUIPC;
            default:    dec_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        cw_d      = cw_q;
        valid_d   = valid_q;
        last_d    = last_q;
        illegal_d = illegal_q;
        if (flush_in) begin
            state_d   = IDLE;
            rem_d     = '0;
            idx_d     = '0;
            cw_d      = '0;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall_in) begin
            case (state_q)
                IDLE: begin
                    rem_d     = '0;
                    idx_d     = '0;
                    cw_d      = '0;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    illegal_d = 1'b0;
                    if (valid_in) begin
                        if (is_memcpy) begin
                            // A zero-length copy is dropped as a NOP.
                            if (len != '0) begin
                                cw_d    = CW_MEMCPY;
                                valid_d = 1'b1;
                                last_d  = (len == CNT_W'(1));
                                if (len != CNT_W'(1)) begin
                                    rem_d   = len - CNT_W'(1);
                                    state_d = COPY;
                                end
                            end
                        end else if (dec_known) begin
                            cw_d    = dec_cw;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end else begin
`ifdef MAINDEC_ILLEGAL_EN
                            valid_d   = 1'b1;
                            last_d    = 1'b1;
                            illegal_d = 1'b1;
`endif
                        end
                    end
                end
                COPY: begin
                    idx_d   = idx_q + CNT_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    valid_d = 1'b1;
                    last_d  = (rem_q == CNT_W'(1));
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            idx_q     <= '0;
            cw_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            cw_q      <= cw_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
        end
    end

    assign {ALUSrc, ALUOp, RegWrite, Branch, immSrc, memwrite1, memwrite2,
            wdsel, jump, resultsrc, jumpsel} = cw_q;
    assign valid_out = valid_q;
    assign uop_idx   = idx_q;
    assign uop_last  = last_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == COPY);

endmodule

// File: tb/tb_maindec_seq.sv
// Directed self-checking bench for maindec_seq: decode table, memcopy bursts, stall, flush, reset.
module tb_maindec_seq;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_MC  = 7'b1000011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [15:0] E_R   = 16'b0_10_1_0_000_0_0_00_0_00_0;
    localparam logic [15:0] E_JAL = 16'b0_00_1_0_011_0_0_00_1_10_0;
    localparam logic [15:0] E_MC  = 16'b1_00_0_0_010_0_1_00_0_00_0;

    logic       clk;
    logic       reset_n;
    logic       valid_in;
    logic [6:0] op;
    logic [4:0] len;
    logic       stall_in;
    logic       flush_in;
    logic       ALUSrc, RegWrite, Branch, memwrite1, memwrite2, jump, jumpsel;
    logic [1:0] ALUOp, wdsel, resultsrc;
    logic [2:0] immSrc;
    logic       valid_out, uop_last, busy, illegal;
    logic [4:0] uop_idx;
    logic [15:0] cw;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    logic [6:0]  ops [9];
    logic [15:0] cws [9];

    maindec_seq #(.CNT_W(5), .MEMCPY_OP(7'b1000011)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .op(op), .len(len),
        .stall_in(stall_in), .flush_in(flush_in),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .Branch(Branch),
        .immSrc(immSrc), .memwrite1(memwrite1), .memwrite2(memwrite2), .wdsel(wdsel),
        .jump(jump), .resultsrc(resultsrc), .jumpsel(jumpsel),
        .valid_out(valid_out), .uop_idx(uop_idx), .uop_last(uop_last),
        .busy(busy), .illegal(illegal)
    );

    assign cw = {ALUSrc, ALUOp, RegWrite, Branch, immSrc, memwrite1, memwrite2,
                 wdsel, jump, resultsrc, jumpsel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] ecw,
                           input logic [4:0] eidx, input logic el, input logic eb);
        chk({tag, ".valid"}, 32'(valid_out), 32'(ev));
        chk({tag, ".cw"},    32'(cw),        32'(ecw));
        chk({tag, ".idx"},   32'(uop_idx),   32'(eidx));
        chk({tag, ".last"},  32'(uop_last),  32'(el));
        chk({tag, ".busy"},  32'(busy),      32'(eb));
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [4:0] l);
        valid_in = v;
        op       = o;
        len      = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        cws = '{16'b0_10_1_0_000_0_0_00_0_00_0, 16'b1_10_1_0_000_0_0_00_0_00_0,
                16'b0_01_0_1_001_0_0_00_0_00_0, 16'b1_00_1_0_000_0_0_01_0_01_0,
                16'b1_00_0_0_010_1_0_00_0_00_0, 16'b0_00_1_0_011_0_0_00_1_10_0,
                16'b0_00_1_0_000_0_0_00_1_10_1, 16'b0_00_1_0_100_0_0_10_0_00_0,
                16'b0_00_1_0_100_0_0_11_0_00_0};
        reset_n  = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        drive(1'b0, 7'd0, 5'd0);

        // Reset state
        repeat (2) cyc();
        chk_all("reset", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        chk("reset.illegal", 32'(illegal), 32'(0));
        reset_n = 1'b1;

        // First R-type after reset
        drive(1'b1, OP_R, 5'd7);
        cyc();
        chk_all("rtype", 1'b1, E_R, 5'd0, 1'b1, 1'b0);

        // Full opcode table back to back
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], 5'd3);
            cyc();
            chk_all($sformatf("table%0d", i), 1'b1, cws[i], 5'd0, 1'b1, 1'b0);
        end

        drive(1'b0, OP_R, 5'd0);
        cyc();
        chk_all("idle", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Memcopy len=3; an R-type is held at the input and only taken after the burst
        drive(1'b1, OP_MC, 5'd3);
        cyc();
        chk_all("mc3.0", 1'b1, E_MC, 5'd0, 1'b0, 1'b1);
        drive(1'b1, OP_R, 5'd0);
        cyc();
        chk_all("mc3.1", 1'b1, E_MC, 5'd1, 1'b0, 1'b1);
        cyc();
        chk_all("mc3.2", 1'b1, E_MC, 5'd2, 1'b1, 1'b0);
        cyc();
        chk_all("mc3.next", 1'b1, E_R, 5'd0, 1'b1, 1'b0);

        // Memcopy len=4 with a two-cycle stall after the first micro-op
        busy_cnt = 0;
        drive(1'b1, OP_MC, 5'd4);
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.0", 1'b1, E_MC, 5'd0, 1'b0, 1'b1);
        drive(1'b0, OP_R, 5'd0);
        stall_in = 1'b1;
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.stall0", 1'b1, E_MC, 5'd0, 1'b0, 1'b1);
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.stall1", 1'b1, E_MC, 5'd0, 1'b0, 1'b1);
        stall_in = 1'b0;
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.1", 1'b1, E_MC, 5'd1, 1'b0, 1'b1);
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.2", 1'b1, E_MC, 5'd2, 1'b0, 1'b1);
        cyc();
        busy_cnt += int'(busy);
        chk_all("mc4.3", 1'b1, E_MC, 5'd3, 1'b1, 1'b0);
        chk("mc4.busy_cycles", 32'(busy_cnt), 32'(5));
        cyc();
        chk_all("mc4.after", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Memcopy len=5 flushed while the second micro-op is visible, then JAL
        drive(1'b1, OP_MC, 5'd5);
        cyc();
        drive(1'b0, OP_R, 5'd0);
        cyc();
        chk_all("mc5.1", 1'b1, E_MC, 5'd1, 1'b0, 1'b1);
        flush_in = 1'b1;
        cyc();
        chk_all("mc5.flush", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        flush_in = 1'b0;
        drive(1'b1, OP_JAL, 5'd0);
        cyc();
        chk_all("jal", 1'b1, E_JAL, 5'd0, 1'b1, 1'b0);

        // Flush wins over a simultaneous stall
        drive(1'b1, OP_MC, 5'd3);
        cyc();
        drive(1'b0, OP_R, 5'd0);
        stall_in = 1'b1;
        flush_in = 1'b1;
        cyc();
        chk_all("flushstall", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        stall_in = 1'b0;
        flush_in = 1'b0;

        // Zero-length then single-word memcopy
        drive(1'b1, OP_MC, 5'd0);
        cyc();
        chk_all("mc0", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, OP_MC, 5'd1);
        cyc();
        chk_all("mc1", 1'b1, E_MC, 5'd0, 1'b1, 1'b0);
        drive(1'b0, OP_R, 5'd0);
        cyc();
        chk_all("mc1.after", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);

        // Unknown opcode, then a legal op clears any illegal flag
        drive(1'b1, OP_BAD, 5'd0);
        cyc();
`ifdef MAINDEC_ILLEGAL_EN
        chk_all("bad", 1'b1, 16'h0, 5'd0, 1'b1, 1'b0);
        chk("bad.illegal", 32'(illegal), 32'(1));
`else
        chk_all("bad", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        chk("bad.illegal", 32'(illegal), 32'(0));
`endif
        drive(1'b1, OP_R, 5'd0);
        cyc();
        chk("bad.clear", 32'(illegal), 32'(0));
        chk_all("bad.next", 1'b1, E_R, 5'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a burst
        drive(1'b1, OP_MC, 5'd5);
        cyc();
        drive(1'b0, OP_R, 5'd0);
        cyc();
        chk_all("mcrst.1", 1'b1, E_MC, 5'd1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("mcrst.async", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
        chk("mcrst.illegal", 32'(illegal), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk_all("mcrst.after", 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
